// File: rtl/signed_divider_if.sv
// signed_divider_if: start/operand and result/status bundle for the signed divider.
interface signed_divider_if #(parameter int N = 8);
    logic           valid;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           done;
    logic           busy;
    logic           div_by_zero;
    logic           overflow;
    modport master (output valid, dividend, divisor,
                    input  quotient, remainder, done, busy, div_by_zero, overflow);
    modport slave  (input  valid, dividend, divisor,
                    output quotient, remainder, done, busy, div_by_zero, overflow);
endinterface

// File: rtl/signed_divider.sv
// signed_divider: 2N/N-bit signed divide, truncating toward zero, one restoring
// step per clock on magnitudes with signs reapplied at the end.
module signed_divider #(parameter int N = 8) (
    input logic clk,
    input logic rst,
    signed_divider_if.slave io
);
    localparam int CW = $clog2(2 * N);
    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N:0]     p_q, p_d;
    logic [2*N-1:0] q_q, q_d, quo_q, quo_d;
    logic [N-1:0]   dvs_q, dvs_d, rem_q, rem_d;
    logic           qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d;
    logic           dbz_q, dbz_d, ovf_q, ovf_d, done_q, done_d;
    logic [N:0]     p_sh;
    logic [N+1:0]   trial;
    assign p_sh  = {p_q[N-1:0], q_q[2*N-1]};
    assign trial = {1'b0, p_sh} - {2'b00, dvs_q};
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (io.valid) begin
                q_d     = io.dividend[2*N-1] ? -io.dividend : io.dividend;
                dvs_d   = io.divisor[N-1] ? -io.divisor : io.divisor;
                qneg_d  = io.dividend[2*N-1] ^ io.divisor[N-1];
                rneg_d  = io.dividend[2*N-1];
                zero_d  = io.divisor == '0;
                p_d     = '0;
                cnt_d   = '0;
                state_d = (io.divisor == '0) ? SIGN : CALC;
            end
            CALC: begin
                p_d     = trial[N+1] ? p_sh : trial[N:0];
                q_d     = {q_q[2*N-2:0], ~trial[N+1]};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(2 * N - 1)) ? SIGN : CALC;
            end
            SIGN: begin
                quo_d   = zero_q ? '0 : (qneg_q ? -q_q : q_q);
                rem_d   = zero_q ? '0 : (rneg_q ? -p_q[N-1:0] : p_q[N-1:0]);
                dbz_d   = zero_q;
                // a positive quotient with the top bit set only arises from -2^(2N-1) / -1
                ovf_d   = ~zero_q & ~qneg_q & q_q[2*N-1];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end
    assign io.quotient    = quo_q;
    assign io.remainder   = rem_q;
    assign io.done        = done_q;
    assign io.busy        = state_q != IDLE;
    assign io.div_by_zero = dbz_q;
    assign io.overflow    = ovf_q;
endmodule

// File: tb/tb_signed_divider.sv
// tb_signed_divider: directed vector table plus reset-abort and back-to-back sequences.
module tb_signed_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    signed_divider_if #(.N(8)) dif ();
    signed_divider #(.N(8)) dut (.clk(clk), .rst(rst), .io(dif));
    always #5 clk = ~clk;
    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
        logic        ovf;
        int          lat;
    } vec_t;
    vec_t vecs[9];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    task automatic run(input logic [15:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        dif.valid = 1'b1;
        dif.dividend = a;
        dif.divisor = b;
        @(posedge clk);
        #1;
        dif.valid = 1'b0;
        dif.dividend = 16'h5A5A;
        dif.divisor = 8'h33;
        check("busy_after_accept", 32'(dif.busy), 32'd1);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (dif.done) break;
        end
        if (!dif.done) check("done_timeout", 32'(dif.done), 32'd1);
    endtask
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int lat, lat2, seen;
        logic [15:0] hold_q;
        vecs[0] = '{16'd100,   8'd7,    16'h000E, 8'h02, 1'b0, 1'b0, 17};
        vecs[1] = '{16'hFF9C,  8'd7,    16'hFFF2, 8'hFE, 1'b0, 1'b0, 17};
        vecs[2] = '{16'd100,   8'hF9,   16'hFFF2, 8'h02, 1'b0, 1'b0, 17};
        vecs[3] = '{16'hFF9C,  8'hF9,   16'h000E, 8'hFE, 1'b0, 1'b0, 17};
        vecs[4] = '{16'h4000,  8'h80,   16'hFF80, 8'h00, 1'b0, 1'b0, 17};
        vecs[5] = '{16'h8000,  8'hFF,   16'h8000, 8'h00, 1'b0, 1'b1, 17};
        vecs[6] = '{16'h8000,  8'h01,   16'h8000, 8'h00, 1'b0, 1'b0, 17};
        vecs[7] = '{16'd1234,  8'h00,   16'h0000, 8'h00, 1'b1, 1'b0, 1};
        vecs[8] = '{16'd9,     8'd3,    16'h0003, 8'h00, 1'b0, 1'b0, 17};
        dif.valid = 1'b0;
        dif.dividend = '0;
        dif.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_quotient", 32'(dif.quotient), 32'd0);
        check("rst_remainder", 32'(dif.remainder), 32'd0);
        check("rst_flags", {28'd0, dif.done, dif.busy, dif.div_by_zero, dif.overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            run(vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_quotient", i), 32'(dif.quotient), 32'(vecs[i].q));
            check($sformatf("v%0d_remainder", i), 32'(dif.remainder), 32'(vecs[i].r));
            check($sformatf("v%0d_dbz", i), 32'(dif.div_by_zero), 32'(vecs[i].dbz));
            check($sformatf("v%0d_ovf", i), 32'(dif.overflow), 32'(vecs[i].ovf));
            check($sformatf("v%0d_busy_in_done", i), 32'(dif.busy), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), 32'(dif.done), 32'd0);
            check($sformatf("v%0d_hold", i), 32'(dif.quotient), 32'(vecs[i].q));
        end
        // reset in the middle of 500 / 3, with valid also high while rst is asserted
        @(negedge clk);
        dif.valid = 1'b1;
        dif.dividend = 16'd500;
        dif.divisor = 8'd3;
        @(posedge clk);
        #1;
        dif.valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        dif.valid = 1'b1;
        #1;
        check("abort_quotient", 32'(dif.quotient), 32'd0);
        check("abort_remainder", 32'(dif.remainder), 32'd0);
        check("abort_flags", {28'd0, dif.done, dif.busy, dif.div_by_zero, dif.overflow}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_beats_valid", 32'(dif.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dif.valid = 1'b0;
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (dif.done || dif.busy) seen++;
        end
        check("no_done_after_abort", 32'(seen), 32'd0);
        run(16'd500, 8'd3, lat);
        check("after_abort_latency", 32'(lat), 32'd17);
        check("after_abort_quotient", 32'(dif.quotient), 32'd166);
        check("after_abort_remainder", 32'(dif.remainder), 32'd2);
        // back-to-back with valid held high and inputs disturbed mid-operation
        @(negedge clk);
        dif.valid = 1'b1;
        dif.dividend = 16'd77;
        dif.divisor = 8'd5;
        @(posedge clk);
        #1;
        dif.dividend = 16'd1000;
        dif.divisor = 8'd1;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 5) begin
                dif.dividend = 16'hFFB3;
                dif.divisor = 8'd5;
            end
            if (dif.done) break;
        end
        check("b2b_first_latency", 32'(lat), 32'd17);
        check("b2b_first_quotient", 32'(dif.quotient), 32'h000F);
        check("b2b_first_remainder", 32'(dif.remainder), 32'h02);
        hold_q = dif.quotient;
        lat2 = 0;
        while (lat2 < 40) begin
            @(posedge clk);
            #1;
            lat2++;
            if (lat2 == 1) begin
                check("b2b_second_accepted", 32'(dif.busy), 32'd1);
                check("b2b_hold_during_second", 32'(dif.quotient), 32'(hold_q));
                dif.valid = 1'b0;
                dif.dividend = 16'd1000;
                dif.divisor = 8'd1;
            end
            if (dif.done) break;
        end
        check("b2b_interval", 32'(lat2), 32'd18);
        check("b2b_second_quotient", 32'(dif.quotient), 32'hFFF1);
        check("b2b_second_remainder", 32'(dif.remainder), 32'hFE);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/signed_divider.md
# signed_divider

Sequential signed divider, the inverse companion of the Booth multiplier: divides a 16-bit two's-complement dividend (typically a product from the multiplier) by an 8-bit two's-complement divisor. It returns a truncated-toward-zero quotient and remainder. It uses the same `valid`/`done` handshake as the multiplier and sits beside it in the arithmetic datapath. Internally it runs a sign-magnitude restoring algorithm, one quotient bit per clock, under an FSM.

## Interface
- `N`, default 8: divisor width. Dividend and quotient are 2N bits wide.
- `clk` in, 1: clock, rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `valid` in, 1: start request; sampled only in IDLE.
- `dividend` in, 2N: signed dividend; captured on acceptance.
- `divisor` in, N: signed divisor; captured on acceptance.
- `quotient` out, 2N: signed quotient, registered.
- `remainder` out, N: signed remainder, registered.
- `done` out, 1: one-cycle pulse; results valid from this cycle on.
- `busy` out, 1: high while an operation is in progress; low in IDLE.
- `div_by_zero` out, 1: status of the last operation; updated together with `done`.
- `overflow` out, 1: status of the last operation; updated together with `done`.

## Operation
- **States:** IDLE, CALC, SIGN.
- **IDLE:**
  - `busy`=0.
  - On `valid`=1, capture the following: |dividend| (2N-bit unsigned), |divisor| (N-bit unsigned, so 128 is representable), sign_q = dividend[2N-1]^divisor[N-1], sign_r = dividend[2N-1].
  - Clear the partial remainder P (N+1 bits) and set count=0.
  - If divisor==0, go to SIGN with the dbz flag set. Otherwise go to CALC.
- **CALC:** performs one restoring step per cycle.
  - Shift {P,Q} left by 1. Q is the 2N-bit magnitude register, initialised to |dividend|.
  - Trial T = P_shifted − |divisor|, computed N+2 bits wide.
  - If T ≥ 0: P=T and Q[0]=1. Otherwise P is restored and Q[0]=0.
  - count increments. After the 2N-th step (count==2N−1), go to SIGN.
- **SIGN:**
  - quotient = sign_q ? −Q : Q, truncated to 2N bits.
  - remainder = sign_r ? −P : P, truncated to N bits.
  - `done`<=1 for one cycle, then go to IDLE.
  - `overflow`=1 only when the dividend is −2^(2N−1) and the divisor is −1. In that case quotient = 0x8000 (wraps) and remainder = 0.
- **Divide by zero:**
  - quotient=0, remainder=0, `div_by_zero`=1, `overflow`=0.
- **Rounding:** results satisfy dividend = quotient·divisor + remainder. |remainder| < |divisor|. The remainder takes the sign of the dividend, or is 0.
- **Output holding:**
  - Outputs hold their values until the next SIGN state.
  - The `div_by_zero` and `overflow` flags are cleared or set only in SIGN.
- **Input handling:**
  - `valid` is ignored while `busy`=1.
  - Input changes after acceptance have no effect.

## Timing
- **Reset values:** `quotient`=0, `remainder`=0, `done`=0, `busy`=0, `div_by_zero`=0, `overflow`=0. State=IDLE, counter=0.
- **Normal latency:**
  - Acceptance edge is E0.
  - E1..E16 are the CALC steps.
  - E17 is SIGN. `done` is high between E17 and E18, and the results are visible at the same time.
  - Total latency is 2N+1 cycles.
- **Divide-by-zero latency:** `done` is high between E1 and E2 (latency 1).
- **`busy`:** high from E0 until the edge where `done` rises. It is low during the `done` cycle.
- **Back-to-back:**
  - `valid` held high during the `done` cycle is accepted at the next edge.
  - Minimum issue interval is 2N+2 cycles.
- **Reset mid-operation:**
  - `rst` asserted in any state immediately clears all state and outputs.
  - No `done` is produced for the aborted operation.
  - After `rst` deasserts, the block waits in IDLE.
- **Simultaneous `valid` and `rst`:** `rst` wins; nothing is captured.

## Test plan
- 100 / 7 → quotient=14 (0x000E), remainder=2. `done` pulses exactly 17 cycles after acceptance. `busy` is high for E0..E16.
- −100 / 7 → 0xFFF2 (−14), rem 0xFE (−2). 100 / −7 → 0xFFF2, rem 0x02. −100 / −7 → 0x000E, rem 0xFE.
- 16384 / −128 → 0xFF80 (−128), rem 0. 0x8000 / −1 → quotient 0x8000, rem 0, `overflow`=1. 0x8000 / 1 → 0x8000, `overflow`=0.
- 1234 / 0 → `div_by_zero`=1, quotient 0, rem 0, `done` one cycle after acceptance. A following 9 / 3 → 3, rem 0, with both flags cleared.
- Assert `rst` at cycle 8 of a 500 / 3 operation → all outputs 0 and no `done`. A new request of 500 / 3 afterwards → 166, rem 2.
- Hold `valid` high continuously with 77 / 5 then −77 / 5. Inputs changed mid-operation are ignored. Results 15 r 2, then 0xFFF1 (−15) r 0xFE (−2). Issue interval is 18 cycles.
